// File: rtl/scroll_controller.sv
// Endless-runner scroll/speed/score sequencer: IDLE/RUN/PAUSE/OVER FSM with speed ramp and BCD score.
// All outputs registered (one-cycle latency from frame_tick); no backpressure, every input is sampled each cycle.
module scroll_controller #(
   parameter int BASE_SPEED   = 2,
   parameter int MAX_SPEED    = 8,
   parameter int RAMP_FRAMES  = 600,
   parameter int SCORE_FRAMES = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic        game_halt,
   input  logic        game_over,
   input  logic        game_reset,
   output logic [10:0] scrolladdr,
   output logic [3:0]  speed,
   output logic        speed_up,
   output logic [15:0] score_bcd,
   output logic [15:0] hiscore_bcd,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam int RW = $clog2(RAMP_FRAMES);
   localparam int SW = $clog2(SCORE_FRAMES);
   localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_FRAMES - 1);
   localparam logic [SW-1:0] SCORE_LAST = SW'(SCORE_FRAMES - 1);
   localparam logic [3:0]    BASE_SPD   = 4'(BASE_SPEED);
   localparam logic [3:0]    MAX_SPD    = 4'(MAX_SPEED);
   localparam logic [15:0]   SCORE_MAX  = 16'h9999;

   state_t        state_q, state_d;
   logic [10:0]   scroll_q, scroll_d;
   logic [3:0]    speed_q, speed_d;
   logic          speed_up_q, speed_up_d;
   logic [15:0]   score_q, score_d;
   logic [15:0]   hiscore_q, hiscore_d;
   logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
   logic [SW-1:0] score_cnt_q, score_cnt_d;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      scroll_d    = scroll_q;
      speed_d     = speed_q;
      speed_up_d  = 1'b0;
      score_d     = score_q;
      hiscore_d   = hiscore_q;
      ramp_cnt_d  = ramp_cnt_q;
      score_cnt_d = score_cnt_q;

      if (game_reset) begin
         state_d     = ST_IDLE;
         scroll_d    = '0;
         speed_d     = BASE_SPD;
         score_d     = '0;
         ramp_cnt_d  = '0;
         score_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // The starting tick only arms the game; it does not move the world.
               if (frame_tick && !game_halt && !game_over) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (game_over) begin
                  state_d = ST_OVER;
                  if (score_q > hiscore_q) hiscore_d = score_q;
               end else if (game_halt) begin
                  state_d = ST_PAUSE;
               end else if (frame_tick) begin
                  scroll_d = scroll_q + {7'd0, speed_q};
                  if (ramp_cnt_q == RAMP_LAST) begin
                     ramp_cnt_d = '0;
                     if (speed_q < MAX_SPD) begin
                        speed_d    = speed_q + 4'd1;
                        speed_up_d = 1'b1;
                     end
                  end else begin
                     ramp_cnt_d = ramp_cnt_q + RW'(1);
                  end
                  if (score_cnt_q == SCORE_LAST) begin
                     score_cnt_d = '0;
                     if (score_q != SCORE_MAX) score_d = bcd_inc(score_q);
                  end else begin
                     score_cnt_d = score_cnt_q + SW'(1);
                  end
               end
            end
            ST_PAUSE: begin
               // Packed BCD with valid digits orders the same as its binary value.
               if (game_over) begin
                  state_d = ST_OVER;
                  if (score_q > hiscore_q) hiscore_d = score_q;
               end else if (!game_halt) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         scroll_q    <= '0;
         speed_q     <= BASE_SPD;
         speed_up_q  <= 1'b0;
         score_q     <= '0;
         hiscore_q   <= '0;
         ramp_cnt_q  <= '0;
         score_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         scroll_q    <= scroll_d;
         speed_q     <= speed_d;
         speed_up_q  <= speed_up_d;
         score_q     <= score_d;
         hiscore_q   <= hiscore_d;
         ramp_cnt_q  <= ramp_cnt_d;
         score_cnt_q <= score_cnt_d;
      end
   end

   assign scrolladdr  = scroll_q;
   assign speed       = speed_q;
   assign speed_up    = speed_up_q;
   assign score_bcd   = score_q;
   assign hiscore_bcd = hiscore_q;
   assign state       = state_q;

endmodule

// File: tb/tb_scroll_controller.sv
// Bench for scroll_controller: instance A uses default parameters, instance B a fast ramp/score
// configuration; both share stimulus and are compared against a decimal-arithmetic game model.
module tb_scroll_controller;

   logic clk;
   logic rst_n;
   logic frame_tick, game_halt, game_over, game_reset;

   logic [10:0] o_scroll [2];
   logic [3:0]  o_speed  [2];
   logic        o_su     [2];
   logic [15:0] o_score  [2];
   logic [15:0] o_hi     [2];
   logic [1:0]  o_state  [2];

   int n_tests = 0;
   int n_fail  = 0;

   localparam int P_BASE  [2] = '{2, 2};
   localparam int P_MAX   [2] = '{8, 3};
   localparam int P_RAMP  [2] = '{600, 4};
   localparam int P_SCORE [2] = '{6, 2};

   // Model state: score kept as a plain decimal integer.
   int m_state [2];
   int m_scroll[2];
   int m_speed [2];
   int m_su    [2];
   int m_score [2];
   int m_hi    [2];
   int m_rc    [2];
   int m_sc    [2];

   scroll_controller u_a (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_halt(game_halt),
      .game_over(game_over), .game_reset(game_reset), .scrolladdr(o_scroll[0]),
      .speed(o_speed[0]), .speed_up(o_su[0]), .score_bcd(o_score[0]),
      .hiscore_bcd(o_hi[0]), .state(o_state[0])
   );

   scroll_controller #(
      .BASE_SPEED(2), .MAX_SPEED(3), .RAMP_FRAMES(4), .SCORE_FRAMES(2)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_halt(game_halt),
      .game_over(game_over), .game_reset(game_reset), .scrolladdr(o_scroll[1]),
      .speed(o_speed[1]), .speed_up(o_su[1]), .score_bcd(o_score[1]),
      .hiscore_bcd(o_hi[1]), .state(o_state[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int to_bcd(input int v);
      return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int i, input bit keep_hi);
      m_state[i]  = 0;
      m_scroll[i] = 0;
      m_speed[i]  = P_BASE[i];
      m_su[i]     = 0;
      m_score[i]  = 0;
      m_rc[i]     = 0;
      m_sc[i]     = 0;
      if (!keep_hi) m_hi[i] = 0;
   endtask

   task automatic model_step(input int i);
      m_su[i] = 0;
      if (game_reset) begin
         model_reset(i, 1'b1);
      end else begin
         case (m_state[i])
            0: if (frame_tick && !game_halt && !game_over) m_state[i] = 1;
            1, 2: begin
               if (game_over) begin
                  m_state[i] = 3;
                  if (m_score[i] > m_hi[i]) m_hi[i] = m_score[i];
               end else if (m_state[i] == 2) begin
                  if (!game_halt) m_state[i] = 1;
               end else if (game_halt) begin
                  m_state[i] = 2;
               end else if (frame_tick) begin
                  m_scroll[i] = (m_scroll[i] + m_speed[i]) % 2048;
                  m_rc[i]++;
                  if (m_rc[i] == P_RAMP[i]) begin
                     m_rc[i] = 0;
                     if (m_speed[i] < P_MAX[i]) begin
                        m_speed[i]++;
                        m_su[i] = 1;
                     end
                  end
                  m_sc[i]++;
                  if (m_sc[i] == P_SCORE[i]) begin
                     m_sc[i] = 0;
                     if (m_score[i] < 9999) m_score[i]++;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_all(input int i);
      string p;
      p = (i == 0) ? "A" : "B";
      chk({p, ".state"},   int'(o_state[i]),  m_state[i]);
      chk({p, ".scroll"},  int'(o_scroll[i]), m_scroll[i]);
      chk({p, ".speed"},   int'(o_speed[i]),  m_speed[i]);
      chk({p, ".speed_up"}, int'(o_su[i]),    m_su[i]);
      chk({p, ".score"},   int'(o_score[i]),  to_bcd(m_score[i]));
      chk({p, ".hiscore"}, int'(o_hi[i]),     to_bcd(m_hi[i]));
   endtask

   task automatic do_cycle(input bit check);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) model_reset(i, 1'b0);
         else model_step(i);
      end
      #1;
      if (check) begin
         check_all(0);
         check_all(1);
      end
   endtask

   task automatic set_in(input logic h, input logic o, input logic r, input logic t);
      game_halt  = h;
      game_over  = o;
      game_reset = r;
      frame_tick = t;
   endtask

   typedef struct {
      logic halt, over, rst, tick;
      int   st, scroll, spd, score, hi;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int guard;
      int pulses;
      int pre_scroll;
      int pre_speed;

      // Expected outputs of instance A after each vector (BASE 2, RAMP 600, SCORE 6).
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0,  2, 'h0, 'h0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 2,  2, 'h0, 'h0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 4,  2, 'h0, 'h0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 6,  2, 'h0, 'h0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 8,  2, 'h0, 'h0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 8,  2, 'h0, 'h0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 8,  2, 'h0, 'h0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 8,  2, 'h0, 'h0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 8,  2, 'h0, 'h0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 10, 2, 'h0, 'h0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 12, 2, 'h1, 'h0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 12, 2, 'h1, 'h1};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 12, 2, 'h1, 'h1};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0,  2, 'h0, 'h1};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0,  2, 'h0, 'h1};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0,  2, 'h0, 'h1};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0,  2, 'h0, 'h1};

      rst_n = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) model_reset(i, 1'b0);
      repeat (3) do_cycle(1'b1);
      chk("A.reset_speed", int'(o_speed[0]), 2);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: start-up, pause/resume, over with tick, restart, IDLE ignoring over/halt.
      for (int v = 0; v < 17; v++) begin
         set_in(tbl[v].halt, tbl[v].over, tbl[v].rst, tbl[v].tick);
         do_cycle(1'b1);
         chk($sformatf("tbl%0d.state", v),  int'(o_state[0]),  tbl[v].st);
         chk($sformatf("tbl%0d.scroll", v), int'(o_scroll[0]), tbl[v].scroll);
         chk($sformatf("tbl%0d.speed", v),  int'(o_speed[0]),  tbl[v].spd);
         chk($sformatf("tbl%0d.score", v),  int'(o_score[0]),  tbl[v].score);
         chk($sformatf("tbl%0d.hi", v),     int'(o_hi[0]),     tbl[v].hi);
      end

      // Scroll wrap on A (passes its first speed ramp on the way).
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      guard = 0;
      while ((m_scroll[0] + m_speed[0]) < 2048 && guard < 3000) begin
         do_cycle(1'b1);
         guard++;
      end
      chk("A.wrap_reached", int'(guard < 3000), 1);
      pre_scroll = m_scroll[0];
      pre_speed  = m_speed[0];
      do_cycle(1'b1);
      chk("A.wrap", int'(o_scroll[0]), pre_scroll + pre_speed - 2048);

      // Speed ramp on B: 2 -> 3 on the fourth RUN tick, one speed_up pulse, then saturated.
      set_in(1'b0, 1'b0, 1'b1, 1'b0);
      do_cycle(1'b1);
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      do_cycle(1'b1);
      pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         do_cycle(1'b1);
         if (o_su[1]) pulses++;
         if (k == 3) chk("B.speed_before_ramp", int'(o_speed[1]), 2);
         if (k == 4) chk("B.speed_after_ramp", int'(o_speed[1]), 3);
      end
      chk("B.speed_up_pulses", pulses, 1);
      chk("B.speed_final", int'(o_speed[1]), 3);

      // BCD carry and saturation on B.
      guard = 0;
      while (m_score[1] != 99 && guard < 1000) begin
         do_cycle(1'b1);
         guard++;
      end
      chk("B.score_0099", int'(o_score[1]), 'h0099);
      do_cycle(1'b1);
      do_cycle(1'b1);
      chk("B.score_0100", int'(o_score[1]), 'h0100);
      guard = 0;
      while (m_score[1] < 9999 && guard < 25000) begin
         do_cycle(1'b0);
         guard++;
      end
      check_all(0);
      check_all(1);
      chk("B.score_9999", int'(o_score[1]), 'h9999);
      repeat (10) do_cycle(1'b1);
      chk("B.score_sat", int'(o_score[1]), 'h9999);
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      do_cycle(1'b1);
      chk("B.hi_9999", int'(o_hi[1]), 'h9999);

      // Asynchronous reset mid-RUN discards the score and the best score.
      set_in(1'b0, 1'b0, 1'b1, 1'b0);
      do_cycle(1'b1);
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (21) do_cycle(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) model_reset(i, 1'b0);
      check_all(0);
      check_all(1);
      chk("A.async_hi", int'(o_hi[0]), 0);
      chk("B.async_hi", int'(o_hi[1]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("A.state_before_edge", int'(o_state[0]), 0);
      do_cycle(1'b1);
      chk("A.state_first_edge", int'(o_state[0]), 1);

      // Game over coincident with a tick at score 42 over a best of 30.
      guard = 0;
      while (m_score[0] != 30 && guard < 1000) begin
         do_cycle(1'b1);
         guard++;
      end
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      do_cycle(1'b1);
      chk("A.hi_0030", int'(o_hi[0]), 'h0030);
      set_in(1'b0, 1'b0, 1'b1, 1'b0);
      do_cycle(1'b1);
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      do_cycle(1'b1);
      guard = 0;
      while (m_score[0] != 42 && guard < 1000) begin
         do_cycle(1'b1);
         guard++;
      end
      chk("A.score_0042", int'(o_score[0]), 'h0042);
      pre_scroll = m_scroll[0];
      set_in(1'b0, 1'b1, 1'b0, 1'b1);
      do_cycle(1'b1);
      chk("A.over_state", int'(o_state[0]), 3);
      chk("A.over_scroll_frozen", int'(o_scroll[0]), pre_scroll);
      chk("A.over_score", int'(o_score[0]), 'h0042);
      chk("A.over_hi", int'(o_hi[0]), 'h0042);
      set_in(1'b0, 1'b0, 1'b1, 1'b0);
      do_cycle(1'b1);
      chk("A.restart_state", int'(o_state[0]), 0);
      chk("A.restart_score", int'(o_score[0]), 0);
      chk("A.restart_hi", int'(o_hi[0]), 'h0042);

      // Pause for 10 ticks mid-RUN, then resume from the frozen values.
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (6) do_cycle(1'b1);
      chk("A.pre_pause_scroll", int'(o_scroll[0]), 10);
      set_in(1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         do_cycle(1'b1);
         chk("A.pause_state", int'(o_state[0]), 2);
         chk("A.pause_scroll", int'(o_scroll[0]), 10);
      end
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      do_cycle(1'b1);
      chk("A.resume_state", int'(o_state[0]), 1);
      chk("A.resume_scroll", int'(o_scroll[0]), 10);
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      do_cycle(1'b1);
      chk("A.resume_tick", int'(o_scroll[0]), 12);

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         set_in(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 31) == 0),
                logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 1)));
         do_cycle(1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
